muldiv_sequencer: RTL and testbench

//  Multicycle multiply/divide controller beside the EX-stage ALU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/mips_pkg.sv | 22 ++
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Funct codes and FSM encoding shared by the mul/div sequencer.
// MULDIV_DIV_EN adds the divide state; without it only MULT/MULTU/MTHI/MTLO exist.
package mips_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
`ifdef MULDIV_DIV_EN
    S_DIV  = 3'd2,
`endif
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage request / HI-LO result bundle for the mul/div sequencer.
// master drives requests (EX stage), slave is the sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, rs_val, rt_val, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, funct, rs_val, rt_val, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the magnitude loop: shift-add multiply or restoring divide.
// Divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
`endif

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // remainder in hi, dividend bits shift out of lo as quotient bits shift in
    sh   = {hi_i, lo_i[WIDTH-1]};
    diff = sh - {1'b0, opnd_i};
    if (div_i) begin
      hi_o = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO.
// Define MULDIV_DIV_EN to include the divide datapath and div_zero.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   whi_q;
  logic [WIDTH-1:0]   wlo_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
`ifdef MULDIV_DIV_EN
  logic               div_q;
  logic               rneg_q;
  logic               dz_q;
  logic               dzp_q;
  logic               is_div;
`endif
  logic               is_mul;
  logic               is_mthi;
  logic               is_mtlo;
  logic               sgn;
  logic               xsgn;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    is_mul  = bus.funct inside {FUNCT_MULT, FUNCT_MULTU};
    is_mthi = bus.funct == FUNCT_MTHI;
    is_mtlo = bus.funct == FUNCT_MTLO;
    sgn     = bus.funct inside {FUNCT_MULT, FUNCT_DIV};
`ifdef MULDIV_DIV_EN
    is_div  = bus.funct inside {FUNCT_DIV, FUNCT_DIVU};
`endif
    rs_mag  = (sgn && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    rt_mag  = (sgn && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    xsgn    = sgn & (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .div_i  (div_q),
`endif
    .hi_i   (whi_q),
    .lo_i   (wlo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    prod = {whi_q, wlo_q};
    if (neg_q) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (div_q) begin
      fix_hi = rneg_q ? -whi_q : whi_q;
      fix_lo = neg_q ? -wlo_q : wlo_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      whi_q   <= '0;
      wlo_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      dzp_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      dz_q   <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            unique case (1'b1)
              is_mthi: begin
                hi_q   <= bus.rs_val;
                done_q <= 1'b1;
              end
              is_mtlo: begin
                lo_q   <= bus.rs_val;
                done_q <= 1'b1;
              end
              is_mul: begin
                state_q <= S_MUL;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                whi_q   <= '0;
                wlo_q   <= rt_mag;
                opnd_q  <= rs_mag;
                neg_q   <= xsgn;
`ifdef MULDIV_DIV_EN
                div_q   <= 1'b0;
                rneg_q  <= 1'b0;
`endif
              end
`ifdef MULDIV_DIV_EN
              is_div: begin
                busy_q <= 1'b1;
                div_q  <= 1'b1;
                dzp_q  <= bus.rt_val == '0;
                if (bus.rt_val == '0) begin
                  state_q <= S_DONE;
                  hi_q    <= bus.rs_val;
                  lo_q    <= '1;
                end else begin
                  state_q <= S_DIV;
                  cnt_q   <= '0;
                  whi_q   <= '0;
                  wlo_q   <= rs_mag;
                  opnd_q  <= rt_mag;
                  neg_q   <= xsgn;
                  rneg_q  <= sgn & bus.rs_val[WIDTH-1];
                end
              end
`endif
              default: ;
            endcase
          end
        end
`ifdef MULDIV_DIV_EN
        S_MUL, S_DIV: begin
`else
        S_MUL: begin
`endif
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            whi_q <= step_hi;
            wlo_q <= step_lo;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= bus.flush ? S_IDLE : S_DONE;
          busy_q  <= !bus.flush;
          if (!bus.flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        S_DONE: begin
          // result is already committed, so a flush here cannot cancel it
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef MULDIV_DIV_EN
          dz_q    <= dzp_q;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_EN
  assign bus.div_zero = dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against an arithmetic HI/LO model.
// Divide scenarios follow MULDIV_DIV_EN as compiled.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam int LAT = W + 2;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_run = 0;
  int n_fail = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  function automatic logic [63:0] ref_mul(input logic [5:0] f,
                                          input logic [W-1:0] a, b);
    longint sa, sb;
    if (f == F_MULT) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

`ifdef MULDIV_DIV_EN
  // returns {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic [5:0] f,
                                          input logic [W-1:0] a, b);
    longint sa, sb;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (f == F_DIV) begin
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, b);
    bus.funct  = f;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  // k = cycles after the accepting edge until done is seen
  task automatic wait_done(output int k, output int nb);
    k = 0;
    nb = 0;
    while (!bus.done && k < 100) begin
      if (bus.busy) nb++;
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.flush = 0; bus.funct = '0;
    bus.rs_val = '0; bus.rt_val = '0;
    reset = 1'b1;
    repeat (2) tick();
    n_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got busy=%b done=%b dz=%b want 0 0 0",
               bus.busy, bus.done, bus.div_zero);
    end
    n_run++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      n_fail++;
      $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi, bus.lo);
    end
    reset = 1'b0;
    tick();
    n_run++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_mul();
    logic [5:0] f;
    logic [W-1:0] a, b;
    logic [63:0] p;
    int k, nb;
    for (int i = 0; i < 10; i++) begin
      f = ($urandom_range(0, 1) == 0) ? F_MULT : F_MULTU;
      a = $urandom;
      b = $urandom;
      case (i)
        0: begin f = F_MULT;  a = -32'sd3;       b = 32'd7; end
        1: begin f = F_MULTU; a = 32'hFFFF_FFFF; b = 32'd2; end
        2: begin f = F_MULT;  a = 32'h8000_0000; b = 32'h8000_0000; end
        3: begin f = F_MULT;  a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin f = F_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      issue(f, a, b);
      wait_done(k, nb);
      p = ref_mul(f, a, b);
      m_hi = p[63:32];
      m_lo = p[31:0];
      n_run++;
      if (k != LAT || nb != LAT) begin
        n_fail++;
        $display("FAIL mul_latency[%0d] got done@%0d busy=%0d want %0d/%0d",
                 i, k, nb, LAT, LAT);
      end
      n_run++;
      if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_result[%0d] f=%b a=%h b=%h got %h_%h busy=%b want %h_%h",
                 i, f, a, b, bus.hi, bus.lo, bus.busy, m_hi, m_lo);
      end
      n_run++;
      if (bus.div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_dz[%0d] got %b want 0", i, bus.div_zero);
      end
      tick();
      n_run++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_done_pulse[%0d] got %b want 0", i, bus.done);
      end
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    logic [5:0] f;
    logic [W-1:0] a, b;
    logic [63:0] r;
    int k, nb;
    for (int i = 0; i < 10; i++) begin
      f = ($urandom_range(0, 1) == 0) ? F_DIV : F_DIVU;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom;
      case (i)
        0: begin f = F_DIV;  a = -32'sd7;       b = 32'd2; end
        1: begin f = F_DIVU; a = 32'd7;         b = 32'd0; end
        2: begin f = F_DIV;  a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin f = F_DIV;  a = -32'sd100;     b = 32'd0; end
        4: begin f = F_DIV;  a = 32'd100;       b = -32'sd7; end
        default: ;
      endcase
      issue(f, a, b);
      wait_done(k, nb);
      r = ref_div(f, a, b);
      m_hi = r[63:32];
      m_lo = r[31:0];
      n_run++;
      if (k != ((b == 0) ? 1 : LAT)) begin
        n_fail++;
        $display("FAIL div_latency[%0d] got %0d want %0d",
                 i, k, (b == 0) ? 1 : LAT);
      end
      n_run++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        n_fail++;
        $display("FAIL div_result[%0d] f=%b a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                 i, f, a, b, bus.hi, bus.lo, m_hi, m_lo);
      end
      n_run++;
      if (bus.div_zero !== (b == 0)) begin
        n_fail++;
        $display("FAIL div_zero[%0d] got %b want %b", i, bus.div_zero, b == 0);
      end
      tick();
    end
  endtask
`else
  task automatic test_div_disabled();
    int nb, nd;
    nb = 0;
    nd = 0;
    issue(F_DIV, 32'd9, 32'd3);
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) nb++;
      if (bus.done) nd++;
      tick();
    end
    issue(F_DIVU, 32'd9, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (bus.busy) nb++;
      if (bus.done || bus.div_zero) nd++;
      tick();
    end
    n_run++;
    if (nb != 0 || nd != 0) begin
      n_fail++;
      $display("FAIL div_ignored busy_cycles=%0d done_cycles=%0d want 0/0", nb, nd);
    end
    n_run++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_fail++;
      $display("FAIL div_ignored_hilo got %h/%h want %h/%h",
               bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [63:0] p;
    int k, nb;
    a = $urandom;
    b = $urandom;
    issue(F_MULT, a, b);
    repeat (4) tick();
    bus.funct  = F_MTLO;
    bus.rs_val = 32'h7B;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    wait_done(k, nb);
    p = ref_mul(F_MULT, a, b);
    m_hi = p[63:32];
    m_lo = p[31:0];
    n_run++;
    if (k != LAT - 5 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_fail++;
      $display("FAIL b2b_ignored got k=%0d %h_%h want k=%0d %h_%h",
               k, bus.hi, bus.lo, LAT - 5, m_hi, m_lo);
    end
    tick();
    issue(F_MTLO, 32'd5, 32'd0);
    m_lo = 32'd5;
    n_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.lo !== m_lo || bus.hi !== m_hi) begin
      n_fail++;
      $display("FAIL mtlo got done=%b busy=%b hi=%h lo=%h want 1 0 %h %h",
               bus.done, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
    end
    tick();
    n_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mtlo_pulse got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    issue(F_MTHI, 32'hA5A5_0001, 32'd0);
    m_hi = 32'hA5A5_0001;
    n_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_fail++;
      $display("FAIL mthi got done=%b busy=%b hi=%h lo=%h want 1 0 %h %h",
               bus.done, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
    end
    tick();
    issue(6'b100000, 32'd1, 32'd1);
    n_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unknown_funct got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_flush();
    logic [63:0] p;
    logic [W-1:0] a, b;
    int nd;
    // flush at three points: mid-loop, in FIX, together with start
    for (int s = 0; s < 3; s++) begin
      bus.funct  = F_MULTU;
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
      bus.start  = 1'b1;
      bus.flush  = (s == 2);
      tick();
      bus.start  = 1'b0;
      if (s == 0) repeat (9) tick();
      if (s == 1) repeat (32) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      n_run++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_idle[%0d] busy got %b want 0", s, bus.busy);
      end
      nd = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.done || bus.busy) nd++;
        tick();
      end
      n_run++;
      if (nd != 0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
        n_fail++;
        $display("FAIL flush_keep[%0d] activity=%0d hi=%h lo=%h want 0 %h %h",
                 s, nd, bus.hi, bus.lo, m_hi, m_lo);
      end
    end
    a = $urandom;
    b = $urandom;
    issue(F_MULT, a, b);
    repeat (33) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    p = ref_mul(F_MULT, a, b);
    m_hi = p[63:32];
    m_lo = p[31:0];
    n_run++;
    if (bus.done !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_fail++;
      $display("FAIL flush_in_done got done=%b %h_%h want 1 %h_%h",
               bus.done, bus.hi, bus.lo, m_hi, m_lo);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int k, nb;
`ifdef MULDIV_DIV_EN
    issue(F_DIV, 32'd1000, 32'd7);
`else
    issue(F_MULT, 32'd1000, 32'd7);
`endif
    repeat (19) tick();
    #2;
    reset = 1'b1;
    #1;
    n_run++;
    if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    m_hi = '0;
    m_lo = '0;
    tick();
    reset = 1'b0;
    tick();
    issue(F_MULTU, 32'd6, 32'd7);
    wait_done(k, nb);
    n_run++;
    if (k != LAT || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      n_fail++;
      $display("FAIL after_reset got k=%0d %h_%h want %0d 0_2a",
               k, bus.hi, bus.lo, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
